// File: rtl/a2d_pkg.sv
// Shared types and constants for the A2D SPI master.
package a2d_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TX1,
        GAP,
        TX2,
        DONE
    } state_t;

    localparam logic [1:0]  CMD_PAD_HI = 2'b00;
    localparam logic [10:0] CMD_PAD_LO = 11'h000;
    localparam int          FRAME_BITS = 16;
    localparam int          BACK_PORCH = 16;

    function automatic logic [FRAME_BITS-1:0] cmd_word(input logic [2:0] ch);
        return {CMD_PAD_HI, ch, CMD_PAD_LO};
    endfunction

endpackage

// File: rtl/a2d_intf_if.sv
// SPI bus between the A2D master and the external converter.
interface a2d_intf_if;

    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (
        output SS_n,
        output SCLK,
        output MOSI,
        input  MISO
    );

    modport slave (
        input  SS_n,
        input  SCLK,
        input  MOSI,
        output MISO
    );

endinterface

// File: rtl/a2d_intf_spi_shift16.sv
// 16-bit SPI shifter: MOSI changes on SCLK fall, MISO captured on SCLK rise.
module spi_shift16
    import a2d_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [FRAME_BITS-1:0] cmd,
    input  logic                  sclk_fall,
    input  logic                  sclk_rise,
    input  logic                  miso,
    output logic                  mosi,
    output logic [11:0]           rx_res,
    output logic                  done_16
);

    logic [FRAME_BITS-1:0] sr;
    logic [4:0]            cnt;

    // One register serves both directions: the outgoing MSB is copied to
    // MOSI on the fall, then the rise shifts it out and the MISO bit in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr   <= '0;
            cnt  <= '0;
            mosi <= 1'b0;
        end else if (load) begin
            sr   <= cmd;
            cnt  <= '0;
            mosi <= 1'b0;
        end else begin
            if (sclk_fall) begin
                mosi <= sr[FRAME_BITS-1];
            end
            if (sclk_rise) begin
                sr  <= {sr[FRAME_BITS-2:0], miso};
                cnt <= cnt + 5'd1;
            end
        end
    end

    assign rx_res  = sr[11:0];
    assign done_16 = (cnt == 5'(FRAME_BITS));

endmodule

// File: rtl/a2d_intf.sv
// SPI master for the 8-channel 12-bit A2D: command frame, gap, result frame.
module a2d_intf
    import a2d_pkg::*;
#(
    parameter int DIV_W    = 5,
    parameter int GAP_CLKS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        strt_cnv,
    input  logic [2:0]  chnnl,
    output logic        cnv_cmplt,
    output logic [11:0] A2D_res,
    a2d_intf_if.master  spi
);

    localparam int HALF = 1 << (DIV_W - 1);
    localparam int GW   = $clog2(GAP_CLKS + 1);

    localparam logic [DIV_W-1:0] DIV_LOAD  = {1'b1, 1'b0, {(DIV_W-2){1'b1}}};
    localparam logic [DIV_W-1:0] DIV_RISE  = {1'b0, {(DIV_W-1){1'b1}}};
    localparam logic [DIV_W-1:0] DIV_FALL  = {DIV_W{1'b1}};
    localparam logic [DIV_W-1:0] PORCH_END = DIV_W'(HALF + BACK_PORCH - 1);
    localparam logic [GW-1:0]    GAP_LAST  = GW'(GAP_CLKS - 1);

    state_t state;
    state_t nxt;

    logic             ss_n;
    logic [DIV_W-1:0] div;
    logic [GW-1:0]    gap_cnt;
    logic [2:0]       chn;

    logic        active;
    logic        start;
    logic        gap_end;
    logic        frame_end;
    logic        load;
    logic        sclk_fall;
    logic        sclk_rise;
    logic        done_16;
    logic        mosi;
    logic [11:0] rx_res;

    assign active    = ~ss_n;
    assign start     = (state == IDLE) && strt_cnv;
    assign gap_end   = (state == GAP) && (gap_cnt == GAP_LAST);
    assign load      = start || gap_end;
    assign sclk_rise = active && (div == DIV_RISE);
    assign sclk_fall = active && (div == DIV_FALL) && !done_16;
    // Back porch ends where the 17th fall would have happened.
    assign frame_end = active && done_16 && (div == PORCH_END);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (strt_cnv)  nxt = TX1;
            TX1:     if (frame_end) nxt = GAP;
            GAP:     if (gap_end)   nxt = TX2;
            TX2:     if (frame_end) nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_n      <= 1'b1;
            div       <= DIV_LOAD;
            gap_cnt   <= '0;
            chn       <= '0;
            cnv_cmplt <= 1'b0;
            A2D_res   <= '0;
        end else begin
            if (load) begin
                ss_n <= 1'b0;
                div  <= DIV_LOAD;
            end else if (frame_end) begin
                ss_n <= 1'b1;
                div  <= DIV_LOAD;
            end else if (active) begin
                div <= div + 1'b1;
            end
            gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
            if (start) begin
                chn       <= chnnl;
                cnv_cmplt <= 1'b0;
            end
            if (state == DONE) begin
                A2D_res   <= rx_res;
                cnv_cmplt <= 1'b1;
            end
        end
    end

    spi_shift16 u_shift (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .cmd       (cmd_word(start ? chnnl : chn)),
        .sclk_fall (sclk_fall),
        .sclk_rise (sclk_rise),
        .miso      (spi.MISO),
        .mosi      (mosi),
        .rx_res    (rx_res),
        .done_16   (done_16)
    );

    assign spi.SS_n = ss_n;
    assign spi.SCLK = div[DIV_W-1];
    assign spi.MOSI = mosi;

endmodule

// File: tb/tb_a2d_intf.sv
// Bench for a2d_intf: behavioural A2D slave, frame monitor, directed vectors.
module tb_a2d_intf;

    localparam int LAT = 2 * (9 + 15 * 32 + 16 + 16) + 32 + 1;

    typedef struct {
        logic [2:0]  ch;
        logic [11:0] res;
        logic [15:0] exp_cmd;
        logic [11:0] exp_res;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] A2D_res;
    logic        miso;

    a2d_intf_if bus ();
    assign bus.MISO = miso;

    a2d_intf dut (
        .clk       (clk),
        .rst       (rst),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .cnv_cmplt (cnv_cmplt),
        .A2D_res   (A2D_res),
        .spi       (bus.master)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [11:0] slave_res = '0;
    logic [11:0] cur_res = '0;

    logic [15:0] mosi_q[$];
    int          rise_q[$];
    int          gap_q[$];
    int          stray = 0;

    int          frame_no = 0;
    int          fi = 0;
    int          rises = 0;
    int          hi_cnt = 0;
    logic [15:0] word = '0;
    logic [15:0] mosi_sh = '0;
    logic        prev_ss = 1'b1;
    logic        prev_sclk = 1'b1;

    always @(negedge clk) begin
        if (rst) begin
            frame_no  = 0;
            hi_cnt    = 0;
            miso      = 1'b0;
            prev_ss   = 1'b1;
            prev_sclk = 1'b1;
        end else begin
            if (prev_ss && !bus.SS_n) begin
                if (frame_no % 2 == 1) gap_q.push_back(hi_cnt);
                word     = (frame_no % 2 == 1) ? {4'hE, slave_res} : 16'hC3C3;
                frame_no = frame_no + 1;
                fi       = 0;
                rises    = 0;
                mosi_sh  = '0;
                miso     = 1'b0;
            end else if (!prev_ss && bus.SS_n) begin
                mosi_q.push_back(mosi_sh);
                rise_q.push_back(rises);
                hi_cnt = 1;
            end else if (bus.SS_n) begin
                hi_cnt = hi_cnt + 1;
            end
            if (!bus.SS_n && prev_sclk && !bus.SCLK && fi < 16) begin
                miso = word[15-fi];
                fi   = fi + 1;
            end
            if (!bus.SS_n && !prev_sclk && bus.SCLK) begin
                mosi_sh = {mosi_sh[14:0], bus.MOSI};
                rises   = rises + 1;
            end
            if (bus.SS_n && prev_ss && (bus.SCLK != prev_sclk)) stray = stray + 1;
            prev_ss   = bus.SS_n;
            prev_sclk = bus.SCLK;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic run_conv(input logic [2:0] ch, input logic [11:0] res,
                            input logic [15:0] exp_cmd, input bit intf);
        int k;
        int holdv;
        slave_res = res;
        @(negedge clk);
        chnnl    = ch;
        strt_cnv = 1'b1;
        @(negedge clk);
        strt_cnv = 1'b0;
        chnnl    = intf ? 3'd7 : ch;
        k        = 0;
        holdv    = 0;
        chk("cmplt_cleared", cnv_cmplt, 0);
        while (cnv_cmplt !== 1'b1 && k < LAT + 100) begin
            if (A2D_res !== cur_res) holdv++;
            @(negedge clk);
            k++;
            strt_cnv = intf && (k == 100 || k == 530 || k == LAT - 1);
            chnnl    = intf ? 3'd7 : ch;
        end
        strt_cnv = 1'b0;
        chk("latency", k, LAT);
        chk("res_hold", holdv, 0);
        chk("A2D_res", A2D_res, res);
        chk("frames", mosi_q.size(), 2);
        chk("gaps", gap_q.size(), 1);
        if (mosi_q.size() >= 2 && rise_q.size() >= 2) begin
            chk("mosi_f1", mosi_q.pop_front(), exp_cmd);
            chk("mosi_f2", mosi_q.pop_front(), exp_cmd);
            chk("rises_f1", rise_q.pop_front(), 16);
            chk("rises_f2", rise_q.pop_front(), 16);
        end
        if (gap_q.size() >= 1) chk("gap_len", gap_q.pop_front(), 32);
        mosi_q.delete();
        rise_q.delete();
        gap_q.delete();
        cur_res = res;
    endtask

    task automatic hold(input int n, input logic [11:0] exp_res);
        int viol;
        viol = 0;
        repeat (n) begin
            @(negedge clk);
            if (cnv_cmplt !== 1'b1 || A2D_res !== exp_res) viol++;
        end
        chk("sticky", viol, 0);
        chk("no_extra_frame", mosi_q.size(), 0);
    endtask

    vec_t tbl[8];

    initial begin
        tbl[0] = '{3'd0, 12'h000, 16'h0000, 12'h000};
        tbl[1] = '{3'd1, 12'hFFF, 16'h0800, 12'hFFF};
        tbl[2] = '{3'd2, 12'h800, 16'h1000, 12'h800};
        tbl[3] = '{3'd3, 12'h001, 16'h1800, 12'h001};
        tbl[4] = '{3'd4, 12'h000, 16'h2000, 12'h000};
        tbl[5] = '{3'd5, 12'hFFF, 16'h2800, 12'hFFF};
        tbl[6] = '{3'd6, 12'h800, 16'h3000, 12'h800};
        tbl[7] = '{3'd7, 12'h001, 16'h3800, 12'h001};

        rst      = 1'b1;
        strt_cnv = 1'b0;
        chnnl    = 3'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        chk("idle_ss_n", bus.SS_n, 1);
        chk("idle_sclk", bus.SCLK, 1);
        chk("idle_mosi", bus.MOSI, 0);
        chk("idle_cmplt", cnv_cmplt, 0);
        chk("idle_res", A2D_res, 12'h000);
        chk("idle_stray", stray, 0);

        run_conv(3'd3, 12'hA5C, 16'h1800, 1'b0);
        hold(1000, 12'hA5C);

        for (int i = 0; i < 8; i++) begin
            run_conv(tbl[i].ch, tbl[i].res, tbl[i].exp_cmd, 1'b0);
            chk("tbl_res", A2D_res, tbl[i].exp_res);
        end

        run_conv(3'd2, 12'h5E1, 16'h1000, 1'b1);
        hold(1200, 12'h5E1);

        slave_res = 12'h777;
        @(negedge clk);
        chnnl    = 3'd5;
        strt_cnv = 1'b1;
        @(negedge clk);
        strt_cnv = 1'b0;
        repeat (790) @(negedge clk);
        chk("pre_rst_ss_n", bus.SS_n, 0);
        chk("pre_rst_sclk", bus.SCLK, 0);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_ss_n", bus.SS_n, 1);
        chk("rst_sclk", bus.SCLK, 1);
        chk("rst_mosi", bus.MOSI, 0);
        chk("rst_cmplt", cnv_cmplt, 0);
        chk("rst_res", A2D_res, 12'h000);
        repeat (3) @(negedge clk);
        rst     = 1'b0;
        cur_res = 12'h000;
        mosi_q.delete();
        rise_q.delete();
        gap_q.delete();
        repeat (5) @(negedge clk);
        chk("post_rst_cmplt", cnv_cmplt, 0);
        run_conv(3'd6, 12'h2B4, 16'h3000, 1'b0);

        run_conv(3'd1, 12'h3E7, 16'h0800, 1'b0);
        run_conv(3'd4, 12'h19B, 16'h2000, 1'b0);
        chk("total_stray", stray, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
